// File: rtl/mem_stage.sv
// Memory-access stage: owns the byte-lane data RAM and produces the MEM/WB bundle.
// Define MEM_BOUNDS_CHECK_EN to reject accesses at or beyond DEPTH_WORDS*4 instead of wrapping.
module mem_stage #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_ram_address,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_load_type,
  input  logic [2:0]  ex_store_type,
  input  logic        ex_misaligned,
  output logic        mem_stall,
  output logic [4:0]  mem_wb_rd,
  output logic [31:0] mem_wb_result,
  output logic        mem_wb_write,
  output logic        mem_wb_is_load,
  output logic        mem_fault,
  output logic        mem_fault_is_store,
  output logic [31:0] mem_fault_addr
);
  typedef enum logic {IDLE, LOAD_RESP} state_t;

  state_t             state;
  logic [3:0][7:0]    ram [DEPTH_WORDS];
  logic [31:0]        rd_data_p1;
  logic [IDX_W-1:0]   idx;
  logic [3:0]         byte_en;
  logic [31:0]        store_word;
  logic               out_of_range;
  logic               in_idle;
  logic               mem_op;
  logic               reject;
  logic               do_store;
  logic               do_load;
  logic               unused_addr;

  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  ltype);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] s;
    b = $signed(word[{off, 3'b000} +: 8]);
    h = $signed(word[{off[1], 4'b0000} +: 16]);
    case (ltype)
      3'b000:  s = 32'(b);
      3'b001:  s = 32'(h);
      3'b100:  s = $signed({24'h0, b});
      3'b101:  s = $signed({16'h0, h});
      default: s = $signed(word);
    endcase
    return $unsigned(s);
  endfunction

`ifdef MEM_BOUNDS_CHECK_EN
  assign out_of_range = (ex_ram_address >= 32'(DEPTH_WORDS * 4));
`else
  assign out_of_range = 1'b0;
`endif

  assign idx         = ex_ram_address[IDX_W+1:2];
  assign unused_addr = ^ex_ram_address[31:IDX_W+2];
  assign in_idle     = (state == IDLE) && !reset;
  assign mem_op      = ex_valid && (ex_is_load || ex_is_store);
  assign reject      = mem_op && (ex_misaligned || out_of_range);
  assign do_store    = in_idle && ex_valid && ex_is_store && !reject;
  assign do_load     = in_idle && ex_valid && ex_is_load && !ex_is_store && !reject;
  assign mem_stall   = do_load;

  always_comb begin
    byte_en    = 4'b0000;
    store_word = ex_store_data;
    case (ex_store_type)
      3'b000: begin
        byte_en[ex_ram_address[1:0]] = 1'b1;
        store_word = {4{ex_store_data[7:0]}};
      end
      3'b001: begin
        byte_en    = ex_ram_address[1] ? 4'b1100 : 4'b0011;
        store_word = {2{ex_store_data[15:0]}};
      end
      default: byte_en = 4'b1111;
    endcase
  end

  // Stage p0 -> p1: RAM write commits, or read word is captured for the response cycle
  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) ram[idx][i] <= store_word[8*i +: 8];
      end
    end
    if (do_load) rd_data_p1 <= ram[idx];
  end

  // Stage p1 -> MEM/WB: writeback bundle and fault pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      mem_wb_rd          <= 5'd0;
      mem_wb_result      <= 32'd0;
      mem_wb_write       <= 1'b0;
      mem_wb_is_load     <= 1'b0;
      mem_fault          <= 1'b0;
      mem_fault_is_store <= 1'b0;
      mem_fault_addr     <= 32'd0;
    end else begin
      mem_fault <= 1'b0;
      case (state)
        IDLE: begin
          mem_wb_write   <= 1'b0;
          mem_wb_is_load <= 1'b0;
          if (reject) begin
            mem_fault          <= 1'b1;
            mem_fault_is_store <= ex_is_store;
            mem_fault_addr     <= ex_ram_address;
          end else if (do_load) begin
            state <= LOAD_RESP;
          end else if (ex_valid && !ex_is_load && !ex_is_store) begin
            mem_wb_rd     <= ex_rd;
            mem_wb_result <= ex_result;
            mem_wb_write  <= ex_reg_write && (ex_rd != 5'd0);
          end
        end
        LOAD_RESP: begin
          mem_wb_rd      <= ex_rd;
          mem_wb_result  <= extract_load(rd_data_p1, ex_ram_address[1:0], ex_load_type);
          mem_wb_write   <= ex_reg_write && (ex_rd != 5'd0);
          mem_wb_is_load <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte-addressed memory model plus per-cycle output comparison.
`timescale 1ns/1ps
module tb_mem_stage;
  localparam int DEPTH = 1024;
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_result = '0;
  logic [31:0] ex_ram_address = '0;
  logic [31:0] ex_store_data = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_reg_write = 1'b0;
  logic        ex_is_load = 1'b0;
  logic        ex_is_store = 1'b0;
  logic [2:0]  ex_load_type = LW;
  logic [2:0]  ex_store_type = SW;
  logic        ex_misaligned = 1'b0;
  logic        mem_stall;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_result;
  logic        mem_wb_write;
  logic        mem_wb_is_load;
  logic        mem_fault;
  logic        mem_fault_is_store;
  logic [31:0] mem_fault_addr;

  mem_stage #(.DEPTH_WORDS(DEPTH), .IDX_W(10)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_ram_address(ex_ram_address), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_load_type(ex_load_type), .ex_store_type(ex_store_type), .ex_misaligned(ex_misaligned),
    .mem_stall(mem_stall), .mem_wb_rd(mem_wb_rd), .mem_wb_result(mem_wb_result),
    .mem_wb_write(mem_wb_write), .mem_wb_is_load(mem_wb_is_load), .mem_fault(mem_fault),
    .mem_fault_is_store(mem_fault_is_store), .mem_fault_addr(mem_fault_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic [7:0]  bmem [DEPTH*4];
  logic        exp_stall = 1'b0;
  logic [4:0]  exp_rd = '0;
  logic [31:0] exp_result = '0;
  logic        exp_write = 1'b0;
  logic        exp_isload = 1'b0;
  logic        exp_fault = 1'b0;
  logic        exp_fault_st = 1'b0;
  logic [31:0] exp_fault_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, want, $time);
    end
  endtask

  function automatic void mdl_store(input logic [2:0] stt, input logic [31:0] addr, input logic [31:0] data);
    int a;
    a = int'(addr % 32'(DEPTH*4));
    case (stt)
      SB: bmem[a] = data[7:0];
      SH: begin
        a = a & ~1;
        bmem[a]   = data[7:0];
        bmem[a+1] = data[15:8];
      end
      default: begin
        a = a & ~3;
        for (int i = 0; i < 4; i++) bmem[a+i] = data[8*i +: 8];
      end
    endcase
  endfunction

  function automatic logic [31:0] mdl_load(input logic [2:0] lt, input logic [31:0] addr);
    int a, h, w;
    a = int'(addr % 32'(DEPTH*4));
    h = a & ~1;
    w = a & ~3;
    case (lt)
      LB:      return {{24{bmem[a][7]}}, bmem[a]};
      LBU:     return {24'h0, bmem[a]};
      LH:      return {{16{bmem[h+1][7]}}, bmem[h+1], bmem[h]};
      LHU:     return {16'h0, bmem[h+1], bmem[h]};
      default: return {bmem[w+3], bmem[w+2], bmem[w+1], bmem[w]};
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_stall", {31'b0, mem_stall}, {31'b0, exp_stall});
      check("mem_wb_rd", {27'b0, mem_wb_rd}, {27'b0, exp_rd});
      check("mem_wb_result", mem_wb_result, exp_result);
      check("mem_wb_write", {31'b0, mem_wb_write}, {31'b0, exp_write});
      check("mem_wb_is_load", {31'b0, mem_wb_is_load}, {31'b0, exp_isload});
      check("mem_fault", {31'b0, mem_fault}, {31'b0, exp_fault});
      check("mem_fault_is_store", {31'b0, mem_fault_is_store}, {31'b0, exp_fault_st});
      check("mem_fault_addr", mem_fault_addr, exp_fault_addr);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the instruction's final edge.
  task automatic issue(input logic v, input logic ld, input logic st,
                       input logic [2:0] lt, input logic [2:0] stt,
                       input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] res,
                       input logic [4:0] rd, input logic rw, input logic mis,
                       output logic st1, output logic st2);
    logic rej, is_st, is_ld;
    ex_valid = v; ex_is_load = ld; ex_is_store = st; ex_load_type = lt; ex_store_type = stt;
    ex_ram_address = addr; ex_store_data = sdata; ex_result = res; ex_rd = rd;
    ex_reg_write = rw; ex_misaligned = mis;
    is_st = v && st;
    is_ld = v && ld && !st;
    rej = v && (ld || st) && (mis || (BOUNDS && addr >= 32'(DEPTH*4)));
    exp_stall = is_ld && !rej;
    st2 = 1'b0;
    @(negedge clk);
    st1 = mem_stall;
    @(posedge clk); #1;
    exp_fault = 1'b0;
    if (rej) begin
      exp_write = 1'b0; exp_isload = 1'b0;
      exp_fault = 1'b1; exp_fault_st = st; exp_fault_addr = addr;
    end else if (is_st) begin
      mdl_store(stt, addr, sdata);
      exp_write = 1'b0; exp_isload = 1'b0;
    end else if (is_ld) begin
      exp_write = 1'b0; exp_isload = 1'b0; exp_stall = 1'b0;
      @(negedge clk);
      st2 = mem_stall;
      @(posedge clk); #1;
      exp_result = mdl_load(lt, addr);
      exp_rd = rd;
      exp_write = rw && (rd != 5'd0);
      exp_isload = 1'b1;
    end else if (v) begin
      exp_rd = rd; exp_result = res;
      exp_write = rw && (rd != 5'd0);
      exp_isload = 1'b0;
    end else begin
      exp_write = 1'b0; exp_isload = 1'b0;
    end
    exp_stall = 1'b0;
  endtask

  task automatic store(input logic [2:0] stt, input logic [31:0] addr, input logic [31:0] data, input logic mis);
    logic s1, s2;
    issue(1'b1, 1'b0, 1'b1, LW, stt, addr, data, 32'h0, 5'd0, 1'b0, mis, s1, s2);
  endtask

  task automatic load(input logic [2:0] lt, input logic [31:0] addr, input logic [4:0] rd,
                      input logic mis, output logic s1, output logic s2);
    issue(1'b1, 1'b1, 1'b0, lt, SW, addr, 32'h0, 32'h0, rd, 1'b1, mis, s1, s2);
  endtask

  task automatic bubble();
    logic s1, s2;
    issue(1'b0, 1'b0, 1'b0, LW, SW, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, s1, s2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic s1, s2;
    for (int i = 0; i < DEPTH*4; i++) bmem[i] = 8'h00;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    check("rst_result", mem_wb_result, 32'h0);
    check("rst_write", {31'b0, mem_wb_write}, 32'h0);
    reset = 1'b0;

    store(SW, 32'h10, 32'hDEADBEEF, 1'b0);
    load(LW, 32'h10, 5'd1, 1'b0, s1, s2);
    check("lw_stall_first", {31'b0, s1}, 32'h1);
    check("lw_stall_resp", {31'b0, s2}, 32'h0);
    check("lw_10", mem_wb_result, 32'hDEADBEEF);
    check("lw_write", {31'b0, mem_wb_write}, 32'h1);
    check("lw_is_load", {31'b0, mem_wb_is_load}, 32'h1);
    load(LB, 32'h13, 5'd2, 1'b0, s1, s2);  check("lb_13", mem_wb_result, 32'hFFFFFFDE);
    load(LBU, 32'h13, 5'd2, 1'b0, s1, s2); check("lbu_13", mem_wb_result, 32'h000000DE);
    load(LH, 32'h12, 5'd3, 1'b0, s1, s2);  check("lh_12", mem_wb_result, 32'hFFFFDEAD);
    load(LHU, 32'h10, 5'd4, 1'b0, s1, s2); check("lhu_10", mem_wb_result, 32'h0000BEEF);

    store(SB, 32'h11, 32'hAAAAAA55, 1'b0);
    load(LW, 32'h10, 5'd6, 1'b0, s1, s2);  check("sb_merge", mem_wb_result, 32'hDEAD55EF);
    store(SH, 32'h12, 32'hFFFF1234, 1'b0);
    load(LW, 32'h10, 5'd7, 1'b0, s1, s2);  check("sh_merge", mem_wb_result, 32'h123455EF);
    load(3'b011, 32'h10, 5'd8, 1'b0, s1, s2); check("ltype_011", mem_wb_result, 32'h123455EF);
    load(3'b110, 32'h11, 5'd8, 1'b0, s1, s2); check("ltype_110", mem_wb_result, 32'h123455EF);

    issue(1'b1, 1'b0, 1'b0, LW, SW, 32'h0, 32'h0, 32'h7, 5'd5, 1'b1, 1'b0, s1, s2);
    check("alu_rd", {27'b0, mem_wb_rd}, 32'd5);
    check("alu_result", mem_wb_result, 32'h7);
    check("alu_write", {31'b0, mem_wb_write}, 32'h1);
    issue(1'b1, 1'b0, 1'b0, LW, SW, 32'h0, 32'h0, 32'h9, 5'd0, 1'b1, 1'b0, s1, s2);
    check("alu_rd0_write", {31'b0, mem_wb_write}, 32'h0);
    bubble();
    check("bubble_write", {31'b0, mem_wb_write}, 32'h0);

    store(SW, 32'h20, 32'hCAFEF00D, 1'b0);
    load(LW, 32'h21, 5'd9, 1'b1, s1, s2);
    check("mis_no_stall", {31'b0, s1}, 32'h0);
    check("mis_fault", {31'b0, mem_fault}, 32'h1);
    check("mis_fault_addr", mem_fault_addr, 32'h21);
    check("mis_fault_is_store", {31'b0, mem_fault_is_store}, 32'h0);
    check("mis_write", {31'b0, mem_wb_write}, 32'h0);
    bubble();
    check("fault_pulse_end", {31'b0, mem_fault}, 32'h0);
    store(SW, 32'h22, 32'h11111111, 1'b1);
    check("mis_st_fault_is_store", {31'b0, mem_fault_is_store}, 32'h1);
    load(LW, 32'h20, 5'd10, 1'b0, s1, s2); check("ram_unchanged", mem_wb_result, 32'hCAFEF00D);

    issue(1'b1, 1'b1, 1'b1, LW, SW, 32'h14, 32'h0BADCAFE, 32'h0, 5'd11, 1'b1, 1'b0, s1, s2);
    check("ld_st_no_stall", {31'b0, s1}, 32'h0);
    load(LW, 32'h14, 5'd11, 1'b0, s1, s2); check("ld_st_as_store", mem_wb_result, 32'h0BADCAFE);

    store(SW, 32'h0, 32'h01020304, 1'b0);
    store(SW, 32'h1000, 32'h5A5A5A5A, 1'b0);
`ifdef MEM_BOUNDS_CHECK_EN
    check("oob_fault", {31'b0, mem_fault}, 32'h1);
    check("oob_fault_addr", mem_fault_addr, 32'h1000);
    load(LW, 32'h0, 5'd12, 1'b0, s1, s2); check("oob_word0", mem_wb_result, 32'h01020304);
`else
    load(LW, 32'h0, 5'd12, 1'b0, s1, s2); check("wrap_word0", mem_wb_result, 32'h5A5A5A5A);
`endif

    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_load_type = LW;
    ex_ram_address = 32'h10; ex_rd = 5'd13; ex_reg_write = 1'b1; ex_misaligned = 1'b0;
    exp_stall = 1'b1;
    @(posedge clk); #1;
    exp_write = 1'b0; exp_isload = 1'b0; exp_fault = 1'b0; exp_stall = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0;
    exp_rd = '0; exp_result = '0; exp_write = 1'b0; exp_isload = 1'b0;
    exp_fault = 1'b0; exp_fault_st = 1'b0; exp_fault_addr = '0;
    check("rst_resp_result", mem_wb_result, 32'h0);
    check("rst_resp_write", {31'b0, mem_wb_write}, 32'h0);
    check("rst_resp_is_load", {31'b0, mem_wb_is_load}, 32'h0);
    bubble();
    check("rst_resp_no_late_wb", {31'b0, mem_wb_write}, 32'h0);
    bubble();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
